// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - default frame geometry and FSM state type for the serial image link
package serial_pkg;
  localparam int DEFAULT_NUM_WORDS = 784;
  localparam int DEFAULT_WORD_W    = 16;
  localparam int DEFAULT_ADDR_W    = 10;

  typedef enum logic [1:0] {IDLE, PRIME, SHIFT, DONE} tx_state_t;
endpackage

// File: rtl/serial_clk_gen.sv
// rtl/serial_clk_gen.sv - divided link clock; strobes flag the edge that toggles serialClock next
module serial_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             toggle;

  always_comb begin
    toggle = enable && (cnt_q == CNT_MAX);
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (enable) begin
      cnt_d  = toggle ? '0 : cnt_q + 1'b1;
      sclk_d = toggle ? ~sclk_q : sclk_q;
    end
  end

  // Strobes are combinational so the FSM updates data on the same edge serialClock falls.
  assign rise_stb = toggle && !sclk_q;
  assign fall_stb = toggle && sclk_q;
  assign sclk     = sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/serial_image_tx.sv
// rtl/serial_image_tx.sv - streams a RAM-held frame LSB first over serialClock/serialData
// SERIAL_TX_FREE_CLK_EN: serialClock free-runs outside frames instead of being gated low.
module serial_image_tx
  import serial_pkg::*;
#(
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int CLK_DIV   = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              serialClock,
  output logic              serialData
);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   NUM_EXT   = (ADDR_W + 1)'(NUM_WORDS);

  tx_state_t         state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d, rd_pend_q, rd_pend_d;
  logic              sdata_q, sdata_d, started_q, started_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d, word_q, word_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d, hold_q, hold_d;
  logic [ADDR_W:0]   next_fetch;
  logic              clk_en, rise_stb, fall_stb;

`ifdef SERIAL_TX_FREE_CLK_EN
  assign clk_en = 1'b1;
`else
  assign clk_en = (state_q == SHIFT);
`endif

  serial_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (CLOCK_50),
    .rst      (reset),
    .enable   (clk_en),
    .sclk     (serialClock),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_pend_d  = rd_en_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    started_d  = started_q;
    last_d     = last_q;
    word_d     = word_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    next_fetch = {1'b0, word_q} + (ADDR_W + 1)'(2);
    case (state_q)
      IDLE: if (start) begin
        state_d   = PRIME;
        busy_d    = 1'b1;
        rd_en_d   = 1'b1;
        addr_d    = '0;
        word_d    = '0;
        bit_d     = '0;
        started_d = 1'b0;
        last_d    = 1'b0;
      end
      PRIME: if (rd_pend_q) begin
        shift_d = mem_rdata;
        state_d = SHIFT;
`ifndef SERIAL_TX_FREE_CLK_EN
        // Gated clock: bit 0 goes out now and word 1 is fetched straight away.
        sdata_d   = mem_rdata[0];
        started_d = 1'b1;
        if (NUM_WORDS > 1) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(1);
        end
`endif
      end
      SHIFT: begin
        if (rd_pend_q) hold_d = mem_rdata;
        if (rise_stb && started_q && bit_q == LAST_BIT && word_q == LAST_WORD) last_d = 1'b1;
        if (fall_stb) begin
          if (last_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sdata_d = 1'b0;
          end else if (!started_q) begin
            started_d = 1'b1;
            sdata_d   = shift_q[0];
            if (NUM_WORDS > 1) begin
              rd_en_d = 1'b1;
              addr_d  = ADDR_W'(1);
            end
          end else if (bit_q == LAST_BIT) begin
            shift_d = hold_q;
            sdata_d = hold_q[0];
            bit_d   = '0;
            word_d  = word_q + 1'b1;
            if (next_fetch < NUM_EXT) begin
              rd_en_d = 1'b1;
              addr_d  = next_fetch[ADDR_W-1:0];
            end
          end else begin
            shift_d = shift_q >> 1;
            sdata_d = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= 1'b0;
      started_q <= 1'b0;
      last_q    <= 1'b0;
      word_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      started_q <= started_d;
      last_q    <= last_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign serialData = sdata_q;
endmodule
